// File: rtl/seq_codes_gray_counter.sv
// Up/down counter with registered binary count and matching Gray code, loadable in either format.
// Define GRAY_COUNTER_SAT_EN for saturating counting with a sticky-per-cycle saturation flag on wrap.
module seq_codes_gray_counter #(
  parameter int nbits = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dn,
  input  logic             ld,
  input  logic             ld_gray,
  input  logic [nbits-1:0] ld_val,
  output logic [nbits-1:0] bin,
  output logic [nbits-1:0] gray,
  output logic             wrap
);

  localparam logic [nbits-1:0] one = nbits'(1);

  function automatic logic [nbits-1:0] bin_to_gray(input logic [nbits-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [nbits-1:0] gray_to_bin(input logic [nbits-1:0] g);
    logic [nbits-1:0] b;
    b[nbits-1] = g[nbits-1];
    for (int i = nbits - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [nbits-1:0] next_bin;
  logic             next_wrap;
  logic             at_bound;

  // Next-state: load beats count beats hold
  always_comb begin
    next_bin  = bin;
    next_wrap = 1'b0;
    at_bound  = dn ? (bin == '0) : (bin == '1);
    if (ld) begin
      next_bin = ld_gray ? gray_to_bin(ld_val) : ld_val;
    end else if (en) begin
`ifdef GRAY_COUNTER_SAT_EN
      if (at_bound) begin
        next_wrap = 1'b1;
      end else begin
        next_bin = dn ? (bin - one) : (bin + one);
      end
`else
      next_bin  = dn ? (bin - one) : (bin + one);
      next_wrap = at_bound;
`endif
    end
  end

  // Gray is derived from the same next value, so bin and gray never skew
  always_ff @(posedge clk) begin
    if (reset) begin
      bin  <= '0;
      gray <= '0;
      wrap <= 1'b0;
    end else begin
      bin  <= next_bin;
      gray <= bin_to_gray(next_bin);
      wrap <= next_wrap;
    end
  end

endmodule

// File: tb/tb_seq_codes_gray_counter.sv
// Scoreboard bench for seq_codes_gray_counter: 4-bit and 8-bit instances, directed vectors.
// Expected values are hand-derived; GRAY_COUNTER_SAT_EN selects the saturating vector set.
module tb_seq_codes_gray_counter;

  typedef struct {
    int    b;
    int    g;
    bit    w;
    bit    onebit;
    string name;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, en, dn, ld, ld_gray;
  logic [3:0] ld_val, bin, gray;
  logic       wrap;

  logic       reset8, en8, dn8, ld8, ld_gray8;
  logic [7:0] ld_val8, bin8, gray8;
  logic       wrap8;

  exp_t q4[$];
  exp_t q8[$];
  int   tests = 0;
  int   fails = 0;
  int   gtab[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

  always #5 clk = ~clk;

  seq_codes_gray_counter #(.nbits(4)) dut4 (
    .clk(clk), .reset(reset), .en(en), .dn(dn), .ld(ld), .ld_gray(ld_gray),
    .ld_val(ld_val), .bin(bin), .gray(gray), .wrap(wrap)
  );

  seq_codes_gray_counter #(.nbits(8)) dut8 (
    .clk(clk), .reset(reset8), .en(en8), .dn(dn8), .ld(ld8), .ld_gray(ld_gray8),
    .ld_val(ld_val8), .bin(bin8), .gray(gray8), .wrap(wrap8)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitors: pop one expectation per presented output cycle
  logic [3:0] prev4;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      chk({e.name, ".bin"}, int'(bin), e.b);
      chk({e.name, ".gray"}, int'(gray), e.g);
      chk({e.name, ".wrap"}, int'(wrap), int'(e.w));
      chk({e.name, ".gray_vs_bin"}, int'(gray), int'(bin ^ (bin >> 1)));
      if (e.onebit) chk({e.name, ".gray_onebit"}, $countones(gray ^ prev4), 1);
    end
    prev4 = gray;
  end

  logic [7:0] prev8;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q8.size() > 0) begin
      e = q8.pop_front();
      chk({e.name, ".bin"}, int'(bin8), e.b);
      chk({e.name, ".gray"}, int'(gray8), e.g);
      chk({e.name, ".wrap"}, int'(wrap8), int'(e.w));
      if (e.onebit) chk({e.name, ".gray_onebit"}, $countones(gray8 ^ prev8), 1);
    end
    prev8 = gray8;
  end

  task automatic step(input bit r, input bit l, input bit lg, input bit e, input bit d,
                      input logic [3:0] v, input int eb, input int eg, input bit ew,
                      input bit ob, input string name);
    exp_t x;
    @(negedge clk);
    reset = r; ld = l; ld_gray = lg; en = e; dn = d; ld_val = v;
    x.b = eb; x.g = eg; x.w = ew; x.onebit = ob; x.name = name;
    q4.push_back(x);
  endtask

  task automatic step8(input bit r, input bit l, input bit e, input bit d,
                       input logic [7:0] v, input int eb, input int eg, input bit ew,
                       input bit ob, input string name);
    exp_t x;
    @(negedge clk);
    reset8 = r; ld8 = l; ld_gray8 = 1'b0; en8 = e; dn8 = d; ld_val8 = v;
    x.b = eb; x.g = eg; x.w = ew; x.onebit = ob; x.name = name;
    q8.push_back(x);
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; dn = 1'b0; ld = 1'b0; ld_gray = 1'b0; ld_val = '0;
    reset8 = 1'b1; en8 = 1'b0; dn8 = 1'b0; ld8 = 1'b0; ld_gray8 = 1'b0; ld_val8 = '0;

    // Reset, then count up through the whole Gray sequence
    step(1, 0, 0, 1, 0, 4'd0, 0, 0, 0, 0, "reset");
    for (int k = 1; k < 16; k++) step(0, 0, 0, 1, 0, 4'd0, k, gtab[k], 0, 1, "up");
`ifdef GRAY_COUNTER_SAT_EN
    step(0, 0, 0, 1, 0, 4'd0, 15, 8, 1, 0, "sat_up_hold");
    step(0, 1, 0, 1, 0, 4'd14, 14, 9, 0, 0, "ld14");
    step(0, 0, 0, 1, 0, 4'd0, 15, 8, 0, 1, "sat_inc1");
    step(0, 0, 0, 1, 0, 4'd0, 15, 8, 1, 0, "sat_inc2");
    step(0, 0, 0, 1, 0, 4'd0, 15, 8, 1, 0, "sat_inc3");
    step(0, 1, 0, 0, 0, 4'd0, 0, 0, 0, 0, "ld0");
    step(0, 0, 0, 1, 1, 4'd0, 0, 0, 1, 0, "sat_dec1");
    step(0, 0, 0, 1, 1, 4'd0, 0, 0, 1, 0, "sat_dec2");
    step(0, 0, 0, 0, 1, 4'd0, 0, 0, 0, 0, "sat_release");
`else
    step(0, 0, 0, 1, 0, 4'd0, 0, 0, 1, 1, "up_wrap");
    step(0, 0, 0, 1, 1, 4'd0, 15, 8, 1, 1, "dn_wrap");
    step(0, 0, 0, 1, 1, 4'd0, 14, 9, 0, 1, "dn_after_wrap");
`endif

    // Loads in both formats, en ignored
    step(0, 1, 1, 1, 0, 4'b1011, 13, 11, 0, 0, "ld_gray");
    step(0, 1, 0, 1, 0, 4'b1011, 11, 14, 0, 0, "ld_bin");

    // Reset wins over a simultaneous load mid-count, then hold
    step(0, 1, 0, 0, 0, 4'd4, 4, 6, 0, 0, "ld4");
    step(0, 0, 0, 1, 0, 4'd0, 5, 7, 0, 1, "up5");
    step(1, 1, 0, 1, 0, 4'd9, 0, 0, 0, 0, "reset_over_ld");
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1, 4'd9, 0, 0, 0, 0, "hold0");

    // Direction reversal every cycle
    step(0, 1, 0, 0, 0, 4'd7, 7, 4, 0, 0, "ld7");
    step(0, 0, 0, 1, 0, 4'd0, 8, 12, 0, 1, "alt_up1");
    step(0, 0, 0, 1, 1, 4'd0, 7, 4, 0, 1, "alt_dn1");
    step(0, 0, 0, 1, 0, 4'd0, 8, 12, 0, 1, "alt_up2");
    step(0, 0, 0, 1, 1, 4'd0, 7, 4, 0, 1, "alt_dn2");
    step(0, 0, 1, 0, 0, 4'd3, 7, 4, 0, 0, "hold7");

    // 8-bit instance near the top
    step8(1, 0, 0, 0, 8'd0, 0, 0, 0, 0, "w8_reset");
    step8(0, 1, 1, 0, 8'd254, 254, 129, 0, 0, "w8_ld254");
    step8(0, 0, 1, 0, 8'd0, 255, 128, 0, 1, "w8_up255");
`ifdef GRAY_COUNTER_SAT_EN
    step8(0, 0, 1, 0, 8'd0, 255, 128, 1, 0, "w8_sat");
`else
    step8(0, 0, 1, 0, 8'd0, 0, 0, 1, 1, "w8_wrap");
`endif
    step8(0, 0, 0, 0, 8'd0, int'(`ifdef GRAY_COUNTER_SAT_EN 255 `else 0 `endif),
          int'(`ifdef GRAY_COUNTER_SAT_EN 128 `else 0 `endif), 0, 0, "w8_hold");

    @(negedge clk);
    en = 1'b0; ld = 1'b0; en8 = 1'b0; ld8 = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (q4.size() != 0 || q8.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d/%0d entries left, expected 0", q4.size(), q8.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_codes_gray_counter.md
Name: seq_codes_gray_counter

Overview:
- Parametrised up/down counter that keeps a registered binary count and its registered reflected-binary Gray code.
- Loadable from either a binary or a Gray-coded value; a Gray load is converted to binary internally.
- Sits in the codes library as the sequential successor to the fixed 4-bit combinational binary-to-Gray converter.
- Drives clock-domain-crossing pointers, so the Gray output must change by exactly one bit per count step.

Parameters:
- nbits, 4, counter width in bits (legal range 2..32).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable.
- dn  input  1  direction: 0 = increment, 1 = decrement; sampled only when counting.
- ld  input  1  load request.
- ld_gray  input  1  load format: 0 = ld_val is binary, 1 = ld_val is Gray code.
- ld_val  input  nbits  load value.
- bin  output  nbits  registered binary count.
- gray  output  nbits  registered Gray code of the count; always equals bin ^ (bin >> 1).
- wrap  output  1  registered one-cycle pulse, high in the cycle after the count wrapped.

Behaviour:
- Reset: bin = 0, gray = 0, wrap = 0 on the first rising edge with reset high. Reset overrides ld and en, including in mid-count.
- Priority each edge: reset > ld > en > hold.
- Load (ld = 1):
  - With ld_gray = 0: bin <= ld_val.
  - With ld_gray = 1: bin <= Gray-to-binary of ld_val, where b[nbits-1] = g[nbits-1] and b[i] = b[i+1] ^ g[i].
  - gray <= Gray code of the new bin.
  - wrap <= 0. en and dn are ignored in a load cycle.
- Count (ld = 0, en = 1):
  - bin <= bin + 1 when dn = 0; bin <= bin - 1 when dn = 1. Arithmetic is modulo 2^nbits.
  - gray updates in the same edge, so bin and gray are never skewed.
- Hold (ld = 0, en = 0): bin, gray unchanged; wrap <= 0.
- wrap <= 1 only on a count edge where:
  - dn = 0 and bin was all-ones (bin becomes 0), or
  - dn = 1 and bin was 0 (bin becomes all-ones).
  - Otherwise wrap <= 0, so a held wrap condition never produces a stretched pulse.
- Latency:
  - One cycle from en, ld or reset to bin, gray and wrap.
  - No combinational path from any input to any output.
- Gray property: across any count edge, gray changes in exactly one bit position. Load edges may change any number of bits.
- dn may change every cycle; a direction reversal costs no idle cycle.

Optional Feature:
- Macro: GRAY_COUNTER_SAT_EN.
- When defined:
  - Counting saturates: increment at all-ones holds all-ones; decrement at 0 holds 0.
  - wrap becomes a saturation flag: high in every cycle after a count edge that was blocked by saturation, low otherwise.
  - Loads and reset behave as without the macro.
- When undefined: modulo wrap-around with the one-cycle wrap pulse, as in Behaviour.

Test Plan (nbits = 4 unless noted):
- Reset, then en = 1, dn = 0 for 16 cycles: bin steps 0..15 and back to 0; gray follows 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8,0; wrap = 1 only in the cycle bin returns to 0. Checker asserts a one-bit gray change per step.
- From bin = 0, en = 1, dn = 1 for one cycle: bin = 15, gray = 8, wrap = 1. Next decrement: bin = 14, gray = 9, wrap = 0.
- Load ld = 1, ld_gray = 1, ld_val = 4'b1011 while en = 1: bin = 13, gray = 11, wrap = 0. Repeat with ld_gray = 0 and the same ld_val: bin = 11, gray = 14.
- Count up to 5, then assert reset together with ld = 1, ld_val = 9: next cycle bin = 0, gray = 0, wrap = 0. Then en = 0 for 3 cycles: outputs hold.
- Alternating dn 0/1 every cycle from bin = 7: bin goes 8,7,8,7 with no stall; wrap stays 0. With nbits = 8, count from 254: bin 255 then 0 with wrap = 1.
- With GRAY_COUNTER_SAT_EN defined: from bin = 14, increment for 3 cycles gives bin 15,15,15 with wrap 0,1,1. Decrement from 0 gives bin stays 0 with wrap = 1.
